stage_if_prefetch: RTL and testbench

Parametrised instruction-fetch stage for the riscv_cpu pipeline, replacing the fixed reg_pc and reg_if_id pair. It generates the sequential PC and issues pipelined requests to an instruction memory with variable latency. Returned instructions are buffered in a DEPTH-entry in-order prefetch queue and handed to stage_id over a valid/ready handshake. A branch/jump redirect flushes the queue and discards responses still in flight.

---
 rtl/stage_if_prefetch_pkg.sv | 11 +
 rtl/stage_if_prefetch_if.sv | 44 ++++
 rtl/stage_if_prefetch_fetch_queue.sv | 78 +++++++
 rtl/stage_if_prefetch.sv | 67 ++++++
 tb/tb_stage_if_prefetch.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_if_prefetch_pkg.sv
// Shared defaults and helpers for the prefetching fetch stage.
// Pointer width carries one extra wrap bit above the slot index.
package stage_if_prefetch_pkg;
  localparam int unsigned ADDR_W_D = 32;
  localparam int unsigned INST_W_D = 32;
  localparam int unsigned DEPTH_D = 4;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/stage_if_prefetch_if.sv
// Instruction-memory request bus and fetch-to-decode handshake.
// The fetch stage is the master of both.
interface rom_bus_if
  import stage_if_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_D,
  parameter int unsigned INST_W = INST_W_D
) ();
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_gnt;
  logic              rom_rvalid;
  logic [INST_W-1:0] rom_inst;

  modport master (
    output rom_ce, rom_addr,
    input  rom_gnt, rom_rvalid, rom_inst
  );
  modport slave (
    input  rom_ce, rom_addr,
    output rom_gnt, rom_rvalid, rom_inst
  );
endinterface

interface id_bus_if
  import stage_if_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_D,
  parameter int unsigned INST_W = INST_W_D
) ();
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_ready;

  modport master (
    output id_valid, id_pc, id_inst,
    input  id_ready
  );
  modport slave (
    input  id_valid, id_pc, id_inst,
    output id_ready
  );
endinterface

// File: rtl/stage_if_prefetch_fetch_queue.sv
// In-order prefetch queue: slots reserved at issue, filled on response.
// Tracks responses still owed to a flushed stream in drop.
module fetch_queue
  import stage_if_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_D,
  parameter int unsigned INST_W = INST_W_D,
  parameter int unsigned DEPTH  = DEPTH_D,
  localparam int unsigned PW = ptr_w(DEPTH),
  localparam int unsigned IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_pc,
  input  logic              rsp_valid,
  input  logic [INST_W-1:0] rsp_inst,
  input  logic              pop,
  input  logic              redirect,
  output logic [PW-1:0]     used,
  output logic [PW-1:0]     drop,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic              orphan
);
  logic [PW-1:0]     wr, fl, rd, drop_q;
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]  filled;
  logic              fill, dec;
  logic [PW-1:0]     drop_sum, drop_redir;

  assign used = wr - rd;
  assign drop = drop_q;
  assign head_valid = (wr != rd) && filled[rd[IW-1:0]];
  assign head_pc = pc_q[rd[IW-1:0]];
  assign head_inst = inst_q[rd[IW-1:0]];
  assign fill = rsp_valid && (drop_q == '0) && (fl != wr);
  assign orphan = rsp_valid && (drop_q == '0) && (fl == wr);

  // A response landing in the redirect cycle is one of the owed ones.
  assign drop_sum = drop_q + (wr - fl);
  assign dec = rsp_valid && (drop_sum != '0);
  assign drop_redir = drop_sum - {{(PW-1){1'b0}}, dec};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr <= '0;
      fl <= '0;
      rd <= '0;
      drop_q <= '0;
      filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        inst_q[i] <= '0;
      end
    end else if (redirect) begin
      fl <= wr;
      rd <= wr;
      drop_q <= drop_redir;
    end else begin
      if (issue) begin
        pc_q[wr[IW-1:0]] <= issue_pc;
        filled[wr[IW-1:0]] <= 1'b0;
        wr <= wr + PW'(1);
      end
      if (fill) begin
        inst_q[fl[IW-1:0]] <= rsp_inst;
        filled[fl[IW-1:0]] <= 1'b1;
        fl <= fl + PW'(1);
      end
      if (pop) rd <= rd + PW'(1);
      if (rsp_valid && (drop_q != '0))
        drop_q <= drop_q - PW'(1);
    end
  end
endmodule

// File: rtl/stage_if_prefetch.sv
// Instruction fetch stage: sequential PC, credit-limited pipelined
// requests, prefetch queue toward decode, redirect flush.
module stage_if_prefetch
  import stage_if_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_D,
  parameter int unsigned INST_W = INST_W_D,
  parameter int unsigned DEPTH  = DEPTH_D,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  rom_bus_if.master         rom,
  id_bus_if.master          id,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              proto_err
);
  localparam int unsigned PW = ptr_w(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_W / 8);

  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0]     used, drop;
  logic [PW:0]       credit_use;
  logic              issue, pop, head_valid, orphan;

  // Slots reserved plus responses owed to a flush share one budget.
  assign credit_use = {1'b0, used} + {1'b0, drop};
  assign rom.rom_ce = (credit_use < (PW+1)'(DEPTH))
                   && !redirect_valid && rst;
  assign rom.rom_addr = fetch_pc;
  assign issue = rom.rom_ce && rom.rom_gnt;
  assign id.id_valid = head_valid && !redirect_valid;
  assign pop = id.id_valid && id.id_ready;

  fetch_queue #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .issue_pc  (fetch_pc),
    .rsp_valid (rom.rom_rvalid),
    .rsp_inst  (rom.rom_inst),
    .pop       (pop),
    .redirect  (redirect_valid),
    .used      (used),
    .drop      (drop),
    .head_valid(head_valid),
    .head_pc   (id.id_pc),
    .head_inst (id.id_inst),
    .orphan    (orphan)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      proto_err <= 1'b0;
    end else begin
      if (redirect_valid) fetch_pc <= redirect_pc;
      else if (issue) fetch_pc <= fetch_pc + STEP;
      if (orphan) proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_stage_if_prefetch.sv
// Bench for stage_if_prefetch: latency-programmable memory model
// and an in-order scoreboard of expected (pc, inst) pops.
module tb_stage_if_prefetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        proto_err;

  rom_bus_if #(.ADDR_W(32), .INST_W(32)) rom_bus ();
  id_bus_if  #(.ADDR_W(32), .INST_W(32)) id_bus ();

  stage_if_prefetch #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom           (rom_bus.master),
    .id            (id_bus.master),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] exp_q[$];
  int          vecs = 0;
  int          miss = 0;
  int          cyc = 0;
  int          npop = 0;
  int          lat = 1;
  logic        rst_r = 1'b0;
  logic        gnt_r = 1'b1;
  logic        ready_r = 1'b1;
  logic        redir_r = 1'b0;
  logic [31:0] redir_pc_r = '0;
  logic        inject_r = 1'b0;
  logic        s_ce, s_valid, s_perr;
  logic [31:0] s_addr, s_pc, s_inst, last_pop_pc;

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 3) ^ 32'h0BAD_F00D;
  endfunction

  // One cycle: drive at negedge, sample, then account for the edge.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    rst = rst_r;
    rom_bus.rom_gnt = gnt_r;
    id_bus.id_ready = ready_r;
    redirect_valid = redir_r;
    redirect_pc = redir_pc_r;
    if (!rst_r) begin
      pend.delete();
      exp_q.delete();
    end
    rom_bus.rom_rvalid = 1'b0;
    rom_bus.rom_inst = '0;
    if (inject_r) begin
      rom_bus.rom_rvalid = 1'b1;
      rom_bus.rom_inst = 32'hDEAD_BEEF;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      rom_bus.rom_rvalid = 1'b1;
      rom_bus.rom_inst = f(pend[0].addr);
      void'(pend.pop_front());
    end
    #1;
    s_ce = rom_bus.rom_ce;
    s_addr = rom_bus.rom_addr;
    s_valid = id_bus.id_valid;
    s_pc = id_bus.id_pc;
    s_inst = id_bus.id_inst;
    s_perr = proto_err;
    if (redir_r) exp_q.delete();
    if (s_ce && gnt_r) begin
      pend.push_back('{addr: s_addr, due: cyc + lat});
      exp_q.push_back(s_addr);
    end
    if (s_valid && ready_r) begin
      vecs++;
      npop++;
      last_pop_pc = s_pc;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL pop_unexpected: got pc %h, want no pop", s_pc);
      end else begin
        e = exp_q.pop_front();
        if (s_pc !== e || s_inst !== f(e)) begin
          miss++;
          $display("FAIL pop: got %h/%h want %h/%h",
                   s_pc, s_inst, e, f(e));
        end
      end
    end
    cyc++;
  endtask

  task automatic pulse_reset();
    rst_r = 1'b0;
    step();
    rst_r = 1'b1;
  endtask

  task automatic test_reset();
    rst_r = 1'b0;
    step();
    step();
    vecs++;
    if (s_ce !== 1'b0) begin
      miss++; $display("FAIL rst_ce: got %b want 0", s_ce);
    end
    vecs++;
    if (s_addr !== 32'h0) begin
      miss++; $display("FAIL rst_addr: got %h want 0", s_addr);
    end
    vecs++;
    if (s_valid !== 1'b0) begin
      miss++; $display("FAIL rst_valid: got %b want 0", s_valid);
    end
    vecs++;
    if (s_pc !== 32'h0 || s_inst !== 32'h0) begin
      miss++; $display("FAIL rst_pc_inst: got %h/%h want 0/0", s_pc, s_inst);
    end
    vecs++;
    if (s_perr !== 1'b0) begin
      miss++; $display("FAIL rst_perr: got %b want 0", s_perr);
    end
  endtask

  task automatic test_stream();
    rst_r = 1'b1; ready_r = 1'b1; gnt_r = 1'b1; lat = 1;
    for (int c = 0; c < 12; c++) begin
      step();
      vecs++;
      if (s_ce !== 1'b1 || s_addr !== 32'(4 * c)) begin
        miss++;
        $display("FAIL stream_req c%0d: got %b/%h want 1/%h",
                 c, s_ce, s_addr, 32'(4 * c));
      end
      vecs++;
      if (c < 2 && s_valid !== 1'b0) begin
        miss++; $display("FAIL stream_early c%0d: got %b want 0", c, s_valid);
      end else if (c >= 2 && (s_valid !== 1'b1 || s_pc !== 32'(4 * (c - 2)))) begin
        miss++;
        $display("FAIL stream_out c%0d: got %b/%h want 1/%h",
                 c, s_valid, s_pc, 32'(4 * (c - 2)));
      end
    end
  endtask

  task automatic test_stall();
    int n;
    pulse_reset();
    ready_r = 1'b0; lat = 1; n = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_ce && gnt_r) n++;
    end
    vecs++;
    if (n !== 4) begin
      miss++; $display("FAIL stall_issues: got %0d want 4", n);
    end
    vecs++;
    if (s_ce !== 1'b0 || s_valid !== 1'b1) begin
      miss++; $display("FAIL stall_full: got ce %b valid %b want 0 1", s_ce, s_valid);
    end
    ready_r = 1'b1;
    for (int r = 0; r < 4; r++) begin
      step();
      vecs++;
      if (s_valid !== 1'b1) begin
        miss++; $display("FAIL drain_valid r%0d: got %b want 1", r, s_valid);
      end
      if (r == 0) begin
        vecs++;
        if (s_ce !== 1'b0) begin
          miss++; $display("FAIL drain_credit: got %b want 0", s_ce);
        end
      end
      if (r == 1) begin
        vecs++;
        if (s_ce !== 1'b1 || s_addr !== 32'h10) begin
          miss++; $display("FAIL resume: got %b/%h want 1/00000010", s_ce, s_addr);
        end
      end
    end
    for (int c = 0; c < 6; c++) step();
  endtask

  task automatic redirect_and_check(input logic [31:0] tgt, input string nm);
    int   mark;
    logic got;
    logic [31:0] first;
    redir_r = 1'b1; redir_pc_r = tgt;
    step();
    redir_r = 1'b0;
    vecs++;
    if (s_valid !== 1'b0 || s_ce !== 1'b0) begin
      miss++;
      $display("FAIL %s_cycle: got valid %b ce %b want 0 0", nm, s_valid, s_ce);
    end
    mark = npop;
    step();
    vecs++;
    if (s_ce !== 1'b1 || s_addr !== tgt) begin
      miss++; $display("FAIL %s_req: got %b/%h want 1/%h", nm, s_ce, s_addr, tgt);
    end
    got = 1'b0; first = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (npop > mark && !got) begin
        got = 1'b1; first = last_pop_pc;
      end
    end
    vecs++;
    if (!got || first !== tgt) begin
      miss++; $display("FAIL %s_first: got %b/%h want 1/%h", nm, got, first, tgt);
    end
  endtask

  task automatic test_redirect();
    int c;
    pulse_reset();
    ready_r = 1'b1; lat = 3; c = 0;
    while (npop == 0 || last_pop_pc !== 32'h0) begin
      step();
      c++;
      if (c > 20) break;
    end
    vecs++;
    if (c > 20) begin
      miss++; $display("FAIL redir_setup: got no pop in 20 cycles, want pc 0");
    end
    redirect_and_check(32'h100, "redir");
  endtask

  task automatic test_redirect_rsp();
    pulse_reset();
    npop = 0;
    ready_r = 1'b1; lat = 2;
    for (int c = 0; c < 3; c++) step();
    redirect_and_check(32'h200, "redir_rsp");
  endtask

  task automatic test_proto_err();
    int mark;
    pulse_reset();
    gnt_r = 1'b0; ready_r = 1'b1; lat = 1;
    step(); step();
    vecs++;
    if (s_perr !== 1'b0) begin
      miss++; $display("FAIL perr_idle: got %b want 0", s_perr);
    end
    inject_r = 1'b1;
    step();
    inject_r = 1'b0;
    step();
    vecs++;
    if (s_perr !== 1'b1 || s_valid !== 1'b0) begin
      miss++; $display("FAIL perr_set: got %b valid %b want 1 0", s_perr, s_valid);
    end
    step(); step(); step();
    vecs++;
    if (s_perr !== 1'b1) begin
      miss++; $display("FAIL perr_sticky: got %b want 1", s_perr);
    end
    gnt_r = 1'b1;
    mark = npop;
    for (int c = 0; c < 8; c++) step();
    vecs++;
    if (npop - mark < 5) begin
      miss++; $display("FAIL perr_flow: got %0d pops want >=5", npop - mark);
    end
  endtask

  task automatic test_reset_pulse();
    pulse_reset();
    ready_r = 1'b0; gnt_r = 1'b1; lat = 3;
    for (int c = 0; c < 5; c++) step();
    rst_r = 1'b0;
    step();
    vecs++;
    if (s_ce !== 1'b0 || s_addr !== 32'h0) begin
      miss++; $display("FAIL pulse_req: got %b/%h want 0/0", s_ce, s_addr);
    end
    vecs++;
    if (s_valid !== 1'b0 || s_pc !== 32'h0 || s_inst !== 32'h0) begin
      miss++;
      $display("FAIL pulse_id: got %b/%h/%h want 0/0/0", s_valid, s_pc, s_inst);
    end
    vecs++;
    if (s_perr !== 1'b0) begin
      miss++; $display("FAIL pulse_perr: got %b want 0", s_perr);
    end
    rst_r = 1'b1; ready_r = 1'b1; lat = 1;
    step();
    vecs++;
    if (s_ce !== 1'b1 || s_addr !== 32'h0) begin
      miss++; $display("FAIL pulse_restart: got %b/%h want 1/0", s_ce, s_addr);
    end
    for (int c = 0; c < 10; c++) step();
  endtask

  initial begin
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    rom_bus.rom_gnt = 1'b0;
    rom_bus.rom_rvalid = 1'b0;
    rom_bus.rom_inst = '0;
    id_bus.id_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rsp();
    test_proto_err();
    test_reset_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
